// File: rtl/wait_event_arbiter_pkg.sv
// Shared types for the wait-event arbiter: FSM states and ack status codes.
package wait_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    LAUNCH = 2'b01,
    BUSY   = 2'b10,
    RESP   = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    ST_OK       = 2'b00,
    ST_TIMEOUT  = 2'b01,
    ST_ERR_IDX  = 2'b10,
    ST_WATCHDOG = 2'b11
  } status_e;

endpackage

// File: rtl/wait_event_arbiter_rr_arbiter.sv
// Round-robin pick: first set request bit scanning upward from ptr+1 (wrapping).
module rr_arbiter #(
  parameter int NB_REQ = 4,
  localparam int PTR_W = $clog2(NB_REQ)
) (
  input  logic [NB_REQ-1:0] req,
  input  logic [PTR_W-1:0]  ptr,
  output logic [NB_REQ-1:0] gnt,
  output logic [PTR_W-1:0]  gnt_idx,
  output logic              any
);

  // cand[i] is the requester examined at scan position i (priority order)
  logic [NB_REQ-1:0][PTR_W-1:0] cand;

  for (genvar i = 0; i < NB_REQ; i++) begin : g_cand
    assign cand[i] = PTR_W'((int'(ptr) + i + 1) % NB_REQ);
  end

  // first hit in priority order wins
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    for (int i = 0; i < NB_REQ; i++) begin
      if (!any && req[cand[i]]) begin
        any            = 1'b1;
        gnt[cand[i]]   = 1'b1;
        gnt_idx        = cand[i];
      end
    end
  end

endmodule

// File: rtl/wait_event_arbiter.sv
// Shares one wait-event engine among NB_REQ sequencer threads: round-robin
// grant, engine launch, watchdog supervision, one-cycle ack with status.
module wait_event_arbiter
  import wait_arb_pkg::*;
#(
  parameter int NB_REQ    = 4,
  parameter int WAIT_SIZE = 5,
  parameter int IDX_W     = 3,
  parameter int TIMEOUT_W = 32,
  parameter int GUARD     = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NB_REQ-1:0]           req_i,
  input  logic [NB_REQ*IDX_W-1:0]     req_idx_i,
  input  logic [NB_REQ-1:0]           req_edge_i,
  input  logic [NB_REQ*TIMEOUT_W-1:0] req_timeout_i,
  output logic [NB_REQ-1:0]           ack_o,
  output logic [1:0]                  status_o,
  output logic [NB_REQ-1:0]           grant_o,
  output logic                        eng_start_o,
  output logic                        eng_abort_o,
  output logic [IDX_W-1:0]            eng_idx_o,
  output logic                        eng_sel_wtr_wtf_o,
  output logic [TIMEOUT_W-1:0]        eng_max_timeout_o,
  input  logic                        eng_done_i,
  input  logic                        eng_timeout_i
);

  localparam int PTR_W = $clog2(NB_REQ);
  localparam logic [IDX_W:0]     WAIT_LIM  = (IDX_W+1)'(WAIT_SIZE);
  localparam logic [TIMEOUT_W:0] GUARD_EXT = (TIMEOUT_W+1)'(GUARD);

  state_e state, state_nxt;
  status_e status_q, status_nxt;

  logic [PTR_W-1:0]     ptr;
  logic [NB_REQ-1:0]    win_oh;
  logic [PTR_W-1:0]     win_sel;
  logic                 win_any;
  logic [IDX_W-1:0]     win_idx;
  logic                 win_edge;
  logic [TIMEOUT_W-1:0] win_tmo;
  logic                 win_bad_idx;
  logic                 win_zero_tmo;

  // watchdog runs one bit wider so timeout + GUARD never wraps
  logic [TIMEOUT_W:0]   wd;
  logic [TIMEOUT_W:0]   wd_limit;

  logic take;      // latch winner this cycle
  logic release_g; // drop ownership this cycle
  logic owner_req;

  rr_arbiter #(.NB_REQ(NB_REQ)) u_rr (
    .req     (req_i),
    .ptr     (ptr),
    .gnt     (win_oh),
    .gnt_idx (win_sel),
    .any     (win_any)
  );

  assign win_idx      = req_idx_i[int'(win_sel)*IDX_W +: IDX_W];
  assign win_edge     = req_edge_i[win_sel];
  assign win_tmo      = req_timeout_i[int'(win_sel)*TIMEOUT_W +: TIMEOUT_W];
  assign win_bad_idx  = {1'b0, win_idx} >= WAIT_LIM;
  assign win_zero_tmo = (win_tmo == '0);

  assign wd_limit  = {1'b0, eng_max_timeout_o} + GUARD_EXT;
  assign owner_req = |(req_i & grant_o);

  assign ack_o    = (state == RESP) ? grant_o : '0;
  assign status_o = (state == RESP) ? status_q : ST_OK;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next state, engine pulses and exit status
  always_comb begin
    state_nxt   = state;
    status_nxt  = status_q;
    take        = 1'b0;
    release_g   = 1'b0;
    eng_start_o = 1'b0;
    eng_abort_o = 1'b0;
    case (state)
      IDLE: begin
        if (win_any) begin
          take = 1'b1;
          if (win_bad_idx) begin
            state_nxt  = RESP;
            status_nxt = ST_ERR_IDX;
          end else if (win_zero_tmo) begin
            state_nxt  = RESP;
            status_nxt = ST_TIMEOUT;
          end else begin
            state_nxt = LAUNCH;
          end
        end
      end
      LAUNCH: begin
        eng_start_o = 1'b1;
        state_nxt   = BUSY;
      end
      BUSY: begin
        // done beats timeout when both arrive together
        if (eng_done_i) begin
          state_nxt  = RESP;
          status_nxt = ST_OK;
        end else if (eng_timeout_i) begin
          state_nxt  = RESP;
          status_nxt = ST_TIMEOUT;
        end else if (!owner_req) begin
          eng_abort_o = 1'b1;
          release_g   = 1'b1;
          state_nxt   = IDLE;
        end else if (wd == wd_limit) begin
          eng_abort_o = 1'b1;
          state_nxt   = RESP;
          status_nxt  = ST_WATCHDOG;
        end
      end
      RESP: begin
        release_g = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // grant, RR pointer, latched request fields and status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_o           <= '0;
      ptr               <= PTR_W'(NB_REQ - 1);
      eng_idx_o         <= '0;
      eng_sel_wtr_wtf_o <= 1'b0;
      eng_max_timeout_o <= '0;
      status_q          <= ST_OK;
    end else begin
      status_q <= status_nxt;
      if (take) begin
        grant_o           <= win_oh;
        ptr               <= win_sel;
        eng_idx_o         <= win_idx;
        eng_sel_wtr_wtf_o <= win_edge;
        eng_max_timeout_o <= win_tmo;
      end else if (release_g) begin
        grant_o <= '0;
      end
    end
  end

  // watchdog: cleared at launch, counts every BUSY cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                wd <= '0;
    else if (state == LAUNCH)  wd <= '0;
    else if (state == BUSY)    wd <= wd + {{TIMEOUT_W{1'b0}}, 1'b1};
  end

endmodule

// File: tb/tb_wait_event_arbiter.sv
// Scoreboard bench: stimulus predicts acks/starts/aborts per grant from the
// arbitration rules; a negedge monitor pops and compares as the DUT emits them.
module tb_wait_event_arbiter;

  localparam int NB = 4, WS = 5, IW = 3, TW = 32, GD = 16;
  localparam int K_DONE = 0, K_TMO = 1, K_BOTH = 2, K_WD = 3, K_DROP = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NB-1:0]    req = '0;
  logic [NB*IW-1:0] req_idx = '0;
  logic [NB-1:0]    req_edge = '0;
  logic [NB*TW-1:0] req_tmo = '0;
  logic             eng_done = 1'b0, eng_timeout = 1'b0;
  logic [NB-1:0]    ack_o, grant_o;
  logic [1:0]       status_o;
  logic             eng_start_o, eng_abort_o, eng_sel_o;
  logic [IW-1:0]    eng_idx_o;
  logic [TW-1:0]    eng_tmo_o;

  wait_event_arbiter #(.NB_REQ(NB), .WAIT_SIZE(WS), .IDX_W(IW), .TIMEOUT_W(TW), .GUARD(GD)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req), .req_idx_i(req_idx), .req_edge_i(req_edge),
    .req_timeout_i(req_tmo), .ack_o(ack_o), .status_o(status_o), .grant_o(grant_o),
    .eng_start_o(eng_start_o), .eng_abort_o(eng_abort_o), .eng_idx_o(eng_idx_o),
    .eng_sel_wtr_wtf_o(eng_sel_o), .eng_max_timeout_o(eng_tmo_o),
    .eng_done_i(eng_done), .eng_timeout_i(eng_timeout)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [NB-1:0] vec;
    logic [1:0]  st;
    int          idx;
    logic        edg;
    int          tmo;
  } exp_t;

  exp_t ack_q[$], start_q[$], abort_q[$];
  exp_t m_e;
  int n_cmp = 0, n_bad = 0;
  int ptr_m = NB - 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_ack"}, ack_o, 0);
    chk({nm, "_status"}, status_o, 0);
    chk({nm, "_grant"}, grant_o, 0);
    chk({nm, "_start"}, eng_start_o, 0);
    chk({nm, "_abort"}, eng_abort_o, 0);
    chk({nm, "_idx"}, eng_idx_o, 0);
    chk({nm, "_sel"}, eng_sel_o, 0);
    chk({nm, "_tmo"}, eng_tmo_o, 0);
  endtask

  // monitor: every DUT event must match the head of its expectation queue
  always @(negedge clk) begin
    if (rst_n) begin
      if (ack_o !== '0) begin
        if (ack_q.size() == 0) chk("unexpected_ack", ack_o, 0);
        else begin
          m_e = ack_q.pop_front();
          chk("ack_cycle", cyc, m_e.cyc);
          chk("ack_vec", ack_o, m_e.vec);
          chk("ack_status", status_o, m_e.st);
        end
      end
      if (eng_start_o !== 1'b0) begin
        if (start_q.size() == 0) chk("unexpected_start", eng_start_o, 0);
        else begin
          m_e = start_q.pop_front();
          chk("start_cycle", cyc, m_e.cyc);
          chk("start_grant", grant_o, m_e.vec);
          chk("start_idx", eng_idx_o, m_e.idx);
          chk("start_edge", eng_sel_o, m_e.edg);
          chk("start_tmo", eng_tmo_o, m_e.tmo);
        end
      end
      if (eng_abort_o !== 1'b0) begin
        if (abort_q.size() == 0) chk("unexpected_abort", eng_abort_o, 0);
        else begin
          m_e = abort_q.pop_front();
          chk("abort_cycle", cyc, m_e.cyc);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_f(input int r, input int idx, input bit edg, input int tmo);
    req_idx[r*IW +: IW] = IW'(idx);
    req_edge[r]         = edg;
    req_tmo[r*TW +: TW] = TW'(tmo);
  endtask

  task automatic rnd_f(input int r);
    int idx, tmo;
    idx = ($urandom % 8 == 0) ? int'($urandom_range(WS, (1 << IW) - 1)) : int'($urandom_range(0, WS - 1));
    tmo = ($urandom % 8 == 0) ? 0 : int'($urandom_range(1, 12));
    set_f(r, idx, 1'($urandom % 2), tmo);
  endtask

  // fields are don't-care outside the winning cycle, so keep them moving
  task automatic step_s();
    step();
    for (int r = 0; r < NB; r++) rnd_f(r);
  endtask

  function automatic int pick();
    for (int i = 1; i <= NB; i++) if (req[(ptr_m + i) % NB]) return (ptr_m + i) % NB;
    return -1;
  endfunction

  // one grant, starting in a cycle where the arbiter is idle
  task automatic episode(input int kind_in, input int d_in);
    int w, c0, e, kind, d, idx, tmo, rk;
    bit edg;
    exp_t x;
    c0 = cyc;
    chk("idle_grant", grant_o, 0);
    w = pick();
    if (w < 0) begin step(); return; end
    ptr_m = w;
    idx = int'(req_idx[w*IW +: IW]);
    edg = req_edge[w];
    tmo = int'(req_tmo[w*TW +: TW]);
    x.vec = '0; x.vec[w] = 1'b1;
    x.idx = idx; x.edg = edg; x.tmo = tmo;
    if (idx >= WS || tmo == 0) begin
      x.cyc = c0 + 1;
      x.st  = (idx >= WS) ? 2'b10 : 2'b01;
      ack_q.push_back(x);
      step_s(); step_s();
      req[w] = 1'b0;
      return;
    end
    x.cyc = c0 + 1;
    start_q.push_back(x);
    if (kind_in >= 0) kind = kind_in;
    else begin
      rk = int'($urandom % 20);
      kind = (rk < 7) ? K_DONE : (rk < 10) ? K_TMO : (rk < 13) ? K_BOTH : (rk < 16) ? K_WD : K_DROP;
    end
    d = (d_in >= 0) ? d_in : int'($urandom_range(0, 5));
    e = (kind == K_WD) ? c0 + 2 + tmo + GD : c0 + 2 + d;
    while (cyc < e) step_s();
    x.st = 2'b00;
    case (kind)
      K_DONE: eng_done = 1'b1;
      K_TMO:  begin eng_timeout = 1'b1; x.st = 2'b01; end
      K_BOTH: begin eng_done = 1'b1; eng_timeout = 1'b1; end
      K_WD:   x.st = 2'b11;
      default: req[w] = 1'b0;
    endcase
    if (kind == K_DROP || kind == K_WD) begin x.cyc = e; abort_q.push_back(x); end
    if (kind != K_DROP) begin x.cyc = e + 1; ack_q.push_back(x); end
    step_s();
    eng_done = 1'b0;
    eng_timeout = 1'b0;
    if (kind != K_DROP) begin
      step_s();
      req[w] = 1'b0;
    end
  endtask

  initial begin
    int w, c0, r;
    exp_t x;
    #2;
    chk_zero("reset");
    step(); step();
    rst_n = 1'b1;

    // round robin with all four held: 0,1,2,3,0
    for (int k = 0; k < 5; k++) begin
      req = '1;
      for (int q = 0; q < NB; q++) set_f(q, q, 1'(q % 2), 30 + q);
      episode(K_DONE, 1);
    end
    req = '0;

    // single request, engine done at cycle 10
    set_f(0, 2, 1'b0, 100); req = 4'b0001;
    episode(K_DONE, 8);

    // engine timeout alone, then done+timeout together
    set_f(1, 1, 1'b1, 40); req = 4'b0010;
    episode(K_TMO, 2);
    set_f(2, 3, 1'b0, 40); req = 4'b0100;
    episode(K_BOTH, 0);

    // invalid requests: index out of range, zero timeout
    set_f(0, 5, 1'b0, 10); req = 4'b0001;
    episode(-1, -1);
    set_f(0, 1, 1'b0, 0); req = 4'b0001;
    episode(-1, -1);

    // watchdog with silent engine
    set_f(3, 4, 1'b1, 20); req = 4'b1000;
    episode(K_WD, 0);

    // owner drops in BUSY, next requester gets the engine
    set_f(0, 0, 1'b0, 50); set_f(1, 2, 1'b1, 50); req = 4'b0011;
    episode(K_DROP, 3);
    set_f(1, 2, 1'b1, 50);
    episode(K_DONE, 2);

    // reset in the middle of BUSY
    set_f(2, 3, 1'b1, 50); req = 4'b0100;
    c0 = cyc;
    w = pick();
    ptr_m = w;
    x.vec = '0; x.vec[w] = 1'b1; x.cyc = c0 + 1; x.idx = 3; x.edg = 1'b1; x.tmo = 50; x.st = 2'b00;
    start_q.push_back(x);
    step_s(); step_s();
    #3;
    rst_n = 1'b0;
    req = '0;
    #1;
    chk_zero("mid_reset");
    step();
    rst_n = 1'b1;
    ptr_m = NB - 1;
    req = '1;
    for (int q = 0; q < NB; q++) set_f(q, q, 1'b0, 20);
    episode(K_DONE, 1);
    req = '0;

    // randomized traffic
    repeat (150) begin
      if (req == '0 && $urandom % 3 == 0) repeat ($urandom_range(1, 3)) step_s();
      for (int q = 0; q < NB; q++)
        if (!req[q] && $urandom % 2 == 1) begin req[q] = 1'b1; rnd_f(q); end
      if (req == '0) begin
        r = int'($urandom % NB);
        req[r] = 1'b1;
        rnd_f(r);
      end
      episode(-1, -1);
    end
    req = '0;
    repeat (4) step();

    chk("pending_acks", ack_q.size(), 0);
    chk("pending_starts", start_q.size(), 0);
    chk("pending_aborts", abort_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wait_event_arbiter.md
Name: wait_event_arbiter

Overview:
- Shares the single wait-event engine between up to NB_REQ independent testbench sequencer threads.
- Each thread posts a request: signal index, edge (rise/fall) and timeout.
- Arbitrates round-robin, launches the engine for the winner, supervises it with a watchdog, and returns a one-cycle ack with a status code.
- Sits between the sequencer threads and the wait event wrapper, in the testbench library.

Parameters:
- NB_REQ, 4, number of requesters (2..16)
- WAIT_SIZE, 5, number of wait signals the engine observes
- IDX_W, 3, width of a wait-signal index (clog2(WAIT_SIZE))
- TIMEOUT_W, 32, width of a timeout value in clk cycles
- GUARD, 16, extra cycles beyond the requested timeout before the watchdog fires

Ports:
- clk  in  1  testbench clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_i  in  NB_REQ  request level per thread; held until its ack
- req_idx_i  in  NB_REQ*IDX_W  wait-signal index per thread (slice r at [r*IDX_W +: IDX_W])
- req_edge_i  in  NB_REQ  0 = wait for rise, 1 = wait for fall
- req_timeout_i  in  NB_REQ*TIMEOUT_W  timeout per thread, in cycles
- ack_o  out  NB_REQ  one-cycle completion pulse to the owning thread
- status_o  out  2  00 OK, 01 TIMEOUT, 10 ERR_IDX, 11 WATCHDOG; valid only while any ack_o bit is high
- grant_o  out  NB_REQ  one-hot current owner; 0 when idle
- eng_start_o  out  1  one-cycle launch pulse to the engine
- eng_abort_o  out  1  one-cycle abort pulse to the engine
- eng_idx_o  out  IDX_W  latched index
- eng_sel_wtr_wtf_o  out  1  latched edge select
- eng_max_timeout_o  out  TIMEOUT_W  latched timeout
- eng_done_i  in  1  engine saw the edge
- eng_timeout_i  in  1  engine timed out

Behaviour:
- Reset, asynchronous and immediate regardless of state:
  - all outputs 0; FSM to IDLE; watchdog counter 0.
  - RR pointer = NB_REQ-1, so requester 0 has first priority.
  - an in-flight request gets no ack.
- FSM states and transitions:
  - IDLE: if any req_i is high, pick the winner as the first set bit scanning from ptr+1 mod NB_REQ.
    - Latch the winner's idx, edge and timeout; set grant_o; set ptr to the winner.
    - Go to LAUNCH, or to RESP if the request is invalid.
  - LAUNCH: eng_start_o = 1 for exactly this cycle; clear the watchdog; go to BUSY.
  - BUSY: increment the watchdog each cycle and check exits in this priority order:
    - eng_done_i -> status OK. If eng_done_i and eng_timeout_i are both high, OK wins.
    - eng_timeout_i -> status TIMEOUT.
    - winner's req_i dropped -> eng_abort_o pulse, go to IDLE, no ack.
    - watchdog == latched timeout + GUARD (computed at TIMEOUT_W+1 bits, no wrap) -> eng_abort_o pulse, status WATCHDOG.
    - The first two exits and the watchdog exit go to RESP.
  - RESP: ack_o[winner] = 1 and status_o valid for 1 cycle; grant_o cleared on exit; go to IDLE.
- Invalid requests (no engine launch, RESP taken directly from IDLE):
  - idx >= WAIT_SIZE -> ERR_IDX.
  - timeout == 0 -> TIMEOUT.
- Latency:
  - req_i rising in IDLE at cycle 0 -> eng_start_o at cycle 1.
  - engine response at cycle k -> ack at cycle k+1.
  - invalid request -> ack at cycle 1.
  - Minimum back-to-back spacing: 4 cycles per grant.
- Requester rules:
  - The requester drops req_i on the edge where it samples ack.
  - Its fields are don't-care except in the IDLE cycle in which it wins.
  - Arbitration resumes in the IDLE cycle after RESP; a still-high req from the previous owner loses to others because of the RR pointer.
- eng_idx_o, eng_sel_wtr_wtf_o and eng_max_timeout_o hold their latched values from LAUNCH until the next grant.

Decomposition:
- Package wait_arb_pkg:
  - state enum (IDLE, LAUNCH, BUSY, RESP)
  - status enum/constants (ST_OK, ST_TIMEOUT, ST_ERR_IDX, ST_WATCHDOG)
- One sub-module: rr_arbiter (combinational first-set-after-pointer search, parameterised by NB_REQ, one-hot plus index output).
- FSM and watchdog stay in the top.

Test Plan:
- Single request: req_i=0001, idx=2, edge=0, timeout=100; eng_done_i at cycle 10 -> eng_start_o at cycle 1, eng_idx_o=2, ack_o=0001 at cycle 11, status=00.
- Round robin: req_i=1111 held; each grant answered with eng_done_i 3 cycles later -> grant order 0,1,2,3,0; status 00 each time.
- Engine timeout vs done: eng_timeout_i alone -> status 01; eng_done_i and eng_timeout_i in the same cycle -> status 00.
- Invalid requests: idx=5 with WAIT_SIZE=5 -> ack at cycle 1, status 10, eng_start_o never high; timeout=0 -> status 01, no start.
- Watchdog: timeout=20, engine silent -> eng_abort_o and then ack with status 11 exactly 20+16 cycles after BUSY entry.
- Abort/reset: owner drops req in BUSY -> eng_abort_o pulse, no ack, next requester granted; rst_n low mid-BUSY -> all outputs 0 immediately, requester 0 wins first after release.
